// File: rtl/rv32_pkg.sv
// Shared RV32I encodings, ALU operation set and the funct3 -> ALU op mapping
// used by the rv32 core.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  // alt selects SUB/SRA; the caller masks it for OP-IMM, which has no SUBI.
  function automatic alu_op_t aluOpDecode(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational integer ALU for the rv32 core; shifts use the low 5 bits of b_i.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/rv32.sv
// Single-cycle RV32I core: decode, register read, execute, memory access and
// writeback all settle within one clock; PC, register file and store commit on the edge.
module rv32
  import rv32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_data_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] instr_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [31:0] rs1Val, rs2Val;
  logic [31:0] pcPlus4, addrI, addrS;
  logic [31:0] aluB, aluResult;
  alu_op_t     aluOp;
  logic        wbEn, storeEn, branchTaken;
  logic [31:0] wbData;

  assign opcode = instr_data_i[6:0];
  assign rd     = instr_data_i[11:7];
  assign funct3 = instr_data_i[14:12];
  assign rs1    = instr_data_i[19:15];
  assign rs2    = instr_data_i[24:20];

  assign immI = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
  assign immS = {{20{instr_data_i[31]}}, instr_data_i[31:25], instr_data_i[11:7]};
  assign immB = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                 instr_data_i[30:25], instr_data_i[11:8], 1'b0};
  assign immU = {instr_data_i[31:12], 12'b0};
  assign immJ = {{11{instr_data_i[31]}}, instr_data_i[31], instr_data_i[19:12],
                 instr_data_i[20], instr_data_i[30:21], 1'b0};

  // Entry 0 is never written after reset, but the read mux makes x0 immune regardless.
  assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  assign pcPlus4 = pc_q + 32'd4;
  assign addrI   = rs1Val + immI;
  assign addrS   = rs1Val + immS;

  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      F3_BEQ:  branchTaken = (rs1Val == rs2Val);
      F3_BNE:  branchTaken = (rs1Val != rs2Val);
      F3_BLT:  branchTaken = ($signed(rs1Val) < $signed(rs2Val));
      F3_BGE:  branchTaken = ($signed(rs1Val) >= $signed(rs2Val));
      F3_BLTU: branchTaken = (rs1Val < rs2Val);
      F3_BGEU: branchTaken = (rs1Val >= rs2Val);
      default: branchTaken = 1'b0;
    endcase
  end

  rv32_alu u_alu (
    .a_i      (rs1Val),
    .b_i      (aluB),
    .op_i     (aluOp),
    .result_o (aluResult)
  );

  // Unlisted opcodes (including all-zero, FENCE, SYSTEM) fall to the default: PC+4 only.
  always_comb begin
    pc_d    = pcPlus4;
    wbEn    = 1'b0;
    wbData  = aluResult;
    storeEn = 1'b0;
    aluB    = immI;
    aluOp   = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        wbEn   = 1'b1;
        wbData = immU;
      end
      OPC_AUIPC: begin
        wbEn   = 1'b1;
        wbData = pc_q + immU;
      end
      OPC_JAL: begin
        wbEn   = 1'b1;
        wbData = pcPlus4;
        pc_d   = pc_q + immJ;
      end
      OPC_JALR: begin
        wbEn   = 1'b1;
        wbData = pcPlus4;
        pc_d   = {addrI[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        if (branchTaken) pc_d = pc_q + immB;
      end
      OPC_LOAD: begin
        wbEn   = 1'b1;
        wbData = mem_data_i;
      end
      OPC_STORE: begin
        storeEn = 1'b1;
      end
      OPC_OP_IMM: begin
        wbEn  = 1'b1;
        aluB  = immI;
        aluOp = aluOpDecode(funct3, (funct3 == F3_SR) && instr_data_i[30]);
      end
      OPC_OP: begin
        wbEn  = 1'b1;
        aluB  = rs2Val;
        aluOp = aluOpDecode(funct3, instr_data_i[30]);
      end
      default: begin
        pc_d = pcPlus4;
      end
    endcase
  end

  assign instr_addr_o = pc_q;
  assign mem_we_o     = storeEn && !rst_i;
  assign mem_addr_o   = rst_i ? 32'd0 : (storeEn ? addrS : addrI);
  assign mem_data_o   = rst_i ? 32'd0 : rs2Val;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (wbEn && (rd != 5'd0)) regs_q[rd] <= wbData;
    end
  end

endmodule

// File: tb/tb_rv32.sv
// Self-checking bench for rv32: a unified word memory feeds both ports and every
// store the core issues is matched against a queue of expected (address, data) pairs.
module tb_rv32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_data_i, mem_data_i;
  logic [31:0] instr_addr_o, mem_addr_o, mem_data_o;
  logic        mem_we_o;

  logic [31:0] mem [256];
  logic        loadWe = 1'b0;
  logic [7:0]  loadAddr = 8'd0;
  logic [31:0] loadData = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } store_t;
  store_t expQ[$];

  int vectorCount = 0;
  int missCount   = 0;

  rv32 dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_data_i (instr_data_i),
    .mem_data_i   (mem_data_i),
    .instr_addr_o (instr_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o)
  );

  always #5 clk_i = ~clk_i;

  assign instr_data_i = mem[instr_addr_o[9:2]];
  assign mem_data_i   = mem[mem_addr_o[9:2]];

  always @(posedge clk_i) begin
    if (loadWe) mem[loadAddr] <= loadData;
    else if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_data_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input int cycles);
    rst_i = rstVal;
    repeat (cycles) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic putWord(input logic [31:0] addr, input logic [31:0] word);
    loadAddr = addr[9:2];
    loadData = word;
    loadWe   = 1'b1;
    @(posedge clk_i);
    #1;
    loadWe = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) putWord(32'(i * 4), 32'd0);
  endtask

  task automatic pushStore(input logic [31:0] addr, input logic [31:0] data);
    store_t s;
    s.addr = addr;
    s.data = data;
    expQ.push_back(s);
  endtask

  // Places "sw rs2, addr(x0)" at pc and expects that store to carry value.
  task automatic putStore(input logic [31:0] pc, input logic [11:0] addr,
                          input logic [4:0] rs2, input logic [31:0] value);
    putWord(pc, encS(addr, rs2, 5'd0));
    pushStore({20'd0, addr}, value);
  endtask

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Reset must silence the data port; outside reset each store must be the next expected one.
  always @(negedge clk_i) begin
    if (rst_i) begin
      checkOutput("rst we", {31'b0, mem_we_o}, 32'd0);
      checkOutput("rst addr", mem_addr_o, 32'd0);
      checkOutput("rst data", mem_data_o, 32'd0);
    end else if (mem_we_o) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious store", {31'b0, mem_we_o}, 32'd0);
      end else begin
        store_t e;
        e = expQ.pop_front();
        checkOutput("st addr", mem_addr_o, e.addr);
        checkOutput("st data", mem_data_o, e.data);
      end
    end
  end

  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] X9 = 5'd9;
  localparam logic [31:0] POISON = 32'h00100493;

  initial begin
    $display("[TB] loading load/add/store program");
    clearMem();
    putWord(32'h00, 32'h04002083);
    putWord(32'h04, 32'h07b08113);
    putWord(32'h08, 32'h03310193);
    putWord(32'h0c, 32'h03f1f193);
    putWord(32'h10, 32'h04302023);
    putWord(32'h14, 32'h00000013);
    putWord(32'h18, 32'h04102223);
    putWord(32'h1c, 32'h04202423);
    putWord(32'h20, 32'h04002203);
    putWord(32'h24, 32'h04402623);
    putWord(32'h28, encJ(21'd0, X0));
    putWord(32'h40, 32'h00000003);

    applyStimulus(1'b1, 2);
    checkOutput("reset pc", instr_addr_o, 32'h0);

    applyStimulus(1'b0, 4);
    checkOutput("pc before abort", instr_addr_o, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1);
      checkOutput("abort pc", instr_addr_o, 32'h0);
    end

    pushStore(32'h40, 32'h31);
    pushStore(32'h44, 32'd3);
    pushStore(32'h48, 32'd126);
    pushStore(32'h4c, 32'h31);
    applyStimulus(1'b0, 6);
    checkOutput("pc after 6", instr_addr_o, 32'h18);
    applyStimulus(1'b0, 10);
    checkOutput("pc loop1", instr_addr_o, 32'h28);
    checkOutput("stores left1", 32'(expQ.size()), 32'd0);

    $display("[TB] loading control-flow and ALU program");
    rst_i = 1'b1;
    clearMem();
    putStore(32'h00, 12'h200, 5'd1, 32'd0);
    putStore(32'h04, 12'h204, 5'd3, 32'd0);
    putWord(32'h08, encU(20'h00001, 5'd7, 7'h17));
    putStore(32'h0c, 12'h208, 5'd7, 32'h1008);
    putWord(32'h10, encI(12'd5, X0, 3'd0, X0, 7'h13));
    putWord(32'h14, encR(7'h00, X0, X0, 3'd0, 5'd1));
    putStore(32'h18, 12'h20c, 5'd1, 32'd0);
    putWord(32'h1c, encU(20'h80000, 5'd5, 7'h37));
    putWord(32'h20, encJ(21'd16, 5'd1));
    putWord(32'h24, encJ(21'h1c, X0));
    putWord(32'h28, POISON);
    putWord(32'h2c, 32'h00000000);
    putWord(32'h30, encI(12'd0, 5'd1, 3'd0, X0, 7'h67));
    putWord(32'h34, POISON);
    putWord(32'h38, POISON);
    putWord(32'h3c, POISON);
    putStore(32'h40, 12'h210, 5'd1, 32'h24);
    putWord(32'h44, encI(12'h404, 5'd5, 3'd5, 5'd6, 7'h13));
    putStore(32'h48, 12'h214, 5'd6, 32'hF800_0000);
    putWord(32'h4c, encI(12'h004, 5'd5, 3'd5, 5'd6, 7'h13));
    putStore(32'h50, 12'h218, 5'd6, 32'h0800_0000);
    putWord(32'h54, encI(12'hFFF, X0, 3'd0, 5'd1, 7'h13));
    putWord(32'h58, encI(12'd1, X0, 3'd0, 5'd2, 7'h13));
    putWord(32'h5c, encB(13'd8, 5'd2, 5'd1, 3'd4));
    putWord(32'h60, POISON);
    putWord(32'h64, encB(13'd8, 5'd2, 5'd1, 3'd6));
    putWord(32'h68, encI(12'd7, X0, 3'd0, 5'd10, 7'h13));
    putStore(32'h6c, 12'h21c, X9, 32'd0);
    putStore(32'h70, 12'h220, 5'd10, 32'd7);
    putWord(32'h74, encR(7'h20, 5'd1, 5'd2, 3'd0, 5'd11));
    putStore(32'h78, 12'h224, 5'd11, 32'd2);
    putWord(32'h7c, encR(7'h00, 5'd2, 5'd1, 3'd2, 5'd12));
    putStore(32'h80, 12'h228, 5'd12, 32'd1);
    putWord(32'h84, encR(7'h00, 5'd2, 5'd1, 3'd3, 5'd13));
    putStore(32'h88, 12'h22c, 5'd13, 32'd0);
    putWord(32'h8c, encR(7'h00, 5'd2, 5'd1, 3'd4, 5'd14));
    putStore(32'h90, 12'h230, 5'd14, 32'hFFFF_FFFE);
    putWord(32'h94, encR(7'h00, 5'd10, 5'd2, 3'd1, 5'd15));
    putStore(32'h98, 12'h234, 5'd15, 32'h80);
    putWord(32'h9c, encR(7'h20, 5'd2, 5'd1, 3'd5, 5'd16));
    putStore(32'ha0, 12'h238, 5'd16, 32'hFFFF_FFFF);
    putWord(32'ha4, encR(7'h00, 5'd10, 5'd1, 3'd5, 5'd17));
    putStore(32'ha8, 12'h23c, 5'd17, 32'h01FF_FFFF);
    putWord(32'hac, encI(12'h070, 5'd2, 3'd6, 5'd18, 7'h13));
    putStore(32'hb0, 12'h240, 5'd18, 32'h71);
    putWord(32'hb4, encI(12'hFFF, 5'd2, 3'd3, 5'd19, 7'h13));
    putStore(32'hb8, 12'h244, 5'd19, 32'd1);
    putWord(32'hbc, encI(12'h0F0, 5'd1, 3'd4, 5'd20, 7'h13));
    putStore(32'hc0, 12'h248, 5'd20, 32'hFFFF_FF0F);
    putWord(32'hc4, encB(13'd8, 5'd1, 5'd2, 3'd5));
    putWord(32'hc8, POISON);
    putWord(32'hcc, encB(13'd8, 5'd1, 5'd2, 3'd7));
    putWord(32'hd0, encI(12'd3, X0, 3'd0, 5'd21, 7'h13));
    putWord(32'hd4, encB(13'd8, 5'd21, 5'd21, 3'd0));
    putWord(32'hd8, POISON);
    putWord(32'hdc, encB(13'd8, 5'd21, 5'd21, 3'd1));
    putWord(32'he0, encI(12'd9, X0, 3'd0, 5'd23, 7'h13));
    putWord(32'he4, 32'h00000073);
    putStore(32'he8, 12'h24c, X9, 32'd0);
    putStore(32'hec, 12'h250, 5'd21, 32'd3);
    putStore(32'hf0, 12'h254, 5'd23, 32'd9);
    putWord(32'hf4, encR(7'h00, 5'd21, 5'd1, 3'd7, 5'd22));
    putStore(32'hf8, 12'h258, 5'd22, 32'd3);
    putWord(32'hfc, encJ(21'd0, X0));

    applyStimulus(1'b1, 2);
    checkOutput("reset pc2", instr_addr_o, 32'h0);
    applyStimulus(1'b0, 80);
    checkOutput("pc loop2", instr_addr_o, 32'hfc);
    checkOutput("stores left2", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
